fifo_tx_feeder: RTL and testbench
=================================

FIFO_TX_FEEDER -- requirements
Module: fifo_tx_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of FIFO read data and TX parallel data.
REQ-002 SHALL have parameter START_TIMEOUT, default 15: cycles to wait for TX_BUSY rise before re-issuing a launch pulse.
REQ-003 SHALL have port R_CLK  input  1  read-domain clock; all logic on rising edge.
REQ-004 SHALL have port R_RST_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port R_EMPTY  input  1  FIFO read-side empty flag.
REQ-006 SHALL have port R_DATA  input  DATA_WIDTH  FIFO memory word at current read address, valid whenever R_EMPTY=0.
REQ-007 SHALL have port R_EN  output  1  FIFO read enable; FIFO pointer advances at the edge where R_EN=1 and R_EMPTY=0.
REQ-008 SHALL have port TX_EN  input  1  feeder enable; 0 blocks new fetches.
REQ-009 SHALL have port TX_BUSY  input  1  UART TX busy, already synchronous to R_CLK.
REQ-010 SHALL have port TX_P_DATA  output  DATA_WIDTH  byte presented to UART TX.
REQ-011 SHALL have port TX_DATA_VALID  output  1  single-cycle launch strobe to UART TX.
REQ-012 SHALL have port SENT_CNT  output  16  count of completed transfers.

Function
REQ-013 SHALL implement FSM states IDLE, LAUNCH, WAIT_START, WAIT_DONE.
REQ-014 SHALL drive R_EN combinationally = (state==IDLE) & TX_EN & ~R_EMPTY & ~TX_BUSY; R_EN SHALL be 0 in all other states.
REQ-015 SHALL, at the edge where R_EN=1, register R_DATA into TX_P_DATA and move IDLE -> LAUNCH.
REQ-016 SHALL hold TX_P_DATA stable from capture until the next capture.
REQ-017 SHALL drive TX_DATA_VALID from a flop, high exactly for the cycles in state LAUNCH (one cycle per entry).
REQ-018 SHALL move LAUNCH -> WAIT_START unconditionally after one cycle, clearing a timeout counter.
REQ-019 SHALL in WAIT_START move to WAIT_DONE when TX_BUSY=1; otherwise increment timeout counter.
REQ-020 SHALL in WAIT_START, when timeout counter reaches START_TIMEOUT with TX_BUSY still 0, return to LAUNCH (re-pulse same TX_P_DATA, no new FIFO read).
REQ-021 SHALL in WAIT_DONE move to IDLE when TX_BUSY=0, incrementing SENT_CNT by 1 at that edge.
REQ-022 SHALL wrap SENT_CNT 16'hFFFF -> 16'h0000 without flag.
REQ-023 SHALL produce at most one FIFO read per completed transfer; back-to-back bytes have minimum spacing IDLE->LAUNCH->WAIT_START->WAIT_DONE->IDLE.
REQ-024 SHALL, when TX_EN falls mid-transfer, finish the current byte (including SENT_CNT update) and then stay in IDLE.
REQ-025 SHALL ignore R_EMPTY changes outside IDLE.
REQ-026 SHALL never assert R_EN while R_EMPTY=1 (no underflow read).
REQ-027 SHALL, when TX_BUSY=1 in IDLE (foreign transmission), withhold R_EN until TX_BUSY=0.

Reset
REQ-028 SHALL on R_RST_n=0, immediately and regardless of clock: state=IDLE, TX_P_DATA=0, TX_DATA_VALID=0, SENT_CNT=0, timeout counter=0; R_EN=0 during reset.
REQ-029 SHALL, on reset during LAUNCH/WAIT_START/WAIT_DONE, abandon the in-flight byte (already popped; not re-read) with no SENT_CNT increment.
REQ-030 SHALL resume normal operation on the first R_CLK edge after R_RST_n deasserts.

Verification
REQ-031 SHALL verify single byte: R_EMPTY=0, R_DATA=8'hA5, TX_EN=1, TX_BUSY=0 -> R_EN=1 one cycle, next cycle TX_P_DATA=8'hA5 and TX_DATA_VALID=1 one cycle; TX_BUSY high 10 cycles then low -> SENT_CNT=1, state IDLE.
REQ-032 SHALL verify empty FIFO: R_EMPTY=1, TX_EN=1 for 20 cycles -> R_EN=0, TX_DATA_VALID=0, SENT_CNT=0 throughout.
REQ-033 SHALL verify timeout: byte 8'h3C launched, TX_BUSY held 0 -> TX_DATA_VALID re-pulses every START_TIMEOUT+2 cycles with TX_P_DATA=8'h3C, R_EN stays 0; TX_BUSY then pulses -> SENT_CNT=1.
REQ-034 SHALL verify burst: FIFO holds 8'h01,8'h02,8'h03, UART model busy 10 cycles per byte -> exactly three R_EN pulses, TX_P_DATA sequence 01,02,03, SENT_CNT=3.
REQ-035 SHALL verify mid-operation reset: assert R_RST_n=0 in WAIT_DONE -> all outputs 0 asynchronously; after release with R_EMPTY=0 next byte fetched, SENT_CNT counts from 0.
REQ-036 SHALL verify wrap and TX_EN gating: SENT_CNT preloaded via 65535 transfers (or forced) -> next completion gives 0; TX_EN dropped during WAIT_START -> byte completes, no further R_EN.

Source files
------------

// File: rtl/fifo_tx_feeder.sv
// Pulls one word at a time from a FIFO read port and hands it to a UART TX,
// re-launching if the transmitter never starts and counting completed bytes.
//
// state      | meaning
// -----------|----------------------------------------------------------
// IDLE       | no byte in flight; fetch when enabled, data present, TX idle
// LAUNCH     | TX_DATA_VALID high for this one cycle
// WAIT_START | waiting for TX_BUSY to rise; re-launch after START_TIMEOUT
// WAIT_DONE  | TX busy with our byte; count it when TX_BUSY falls
module fifo_tx_feeder #(
   parameter int DATA_WIDTH    = 8,
   parameter int START_TIMEOUT = 15
) (
   input  logic                  R_CLK,
   input  logic                  R_RST_n,
   input  logic                  R_EMPTY,
   input  logic [DATA_WIDTH-1:0] R_DATA,
   output logic                  R_EN,
   input  logic                  TX_EN,
   input  logic                  TX_BUSY,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_DATA_VALID,
   output logic [15:0]           SENT_CNT
);

   localparam int TW = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_START,
      WAIT_DONE
   } state_t;

   state_t        state;
   logic [TW-1:0] to_cnt;

   // Reset term keeps the read enable quiet while the FIFO may still be stepping.
   assign R_EN = R_RST_n & (state == IDLE) & TX_EN & ~R_EMPTY & ~TX_BUSY;

   always_ff @(posedge R_CLK or negedge R_RST_n) begin
      if (!R_RST_n) begin
         state         <= IDLE;
         to_cnt        <= '0;
         TX_P_DATA     <= '0;
         TX_DATA_VALID <= 1'b0;
         SENT_CNT      <= 16'd0;
      end else begin
         TX_DATA_VALID <= 1'b0;
         case (state)
            IDLE: begin
               if (R_EN) begin
                  TX_P_DATA     <= R_DATA;
                  TX_DATA_VALID <= 1'b1;
                  state         <= LAUNCH;
               end
            end
            LAUNCH: begin
               to_cnt <= '0;
               state  <= WAIT_START;
            end
            WAIT_START: begin
               if (TX_BUSY) begin
                  state <= WAIT_DONE;
               end else if (to_cnt == TO_LAST) begin
                  // Re-pulse the held byte; nothing new is read from the FIFO.
                  TX_DATA_VALID <= 1'b1;
                  state         <= LAUNCH;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!TX_BUSY) begin
                  SENT_CNT <= SENT_CNT + 16'd1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_tx_feeder.sv
// Randomised and directed bench for fifo_tx_feeder against a transfer-level
// model: a byte is "in flight" from fetch until TX_BUSY has risen and fallen.
module tb_fifo_tx_feeder;

   localparam int ST = 15;
   localparam int PER = ST + 2;

   logic       R_CLK = 1'b0;
   logic       R_RST_n = 1'b0;
   logic       R_EMPTY = 1'b1;
   logic [7:0] R_DATA = 8'h00;
   logic       TX_EN = 1'b0;
   logic       TX_BUSY = 1'b0;
   logic       R_EN;
   logic [7:0] TX_P_DATA;
   logic       TX_DATA_VALID;
   logic [15:0] SENT_CNT;

   fifo_tx_feeder #(.DATA_WIDTH(8), .START_TIMEOUT(ST)) dut (
      .R_CLK(R_CLK), .R_RST_n(R_RST_n), .R_EMPTY(R_EMPTY), .R_DATA(R_DATA),
      .R_EN(R_EN), .TX_EN(TX_EN), .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA),
      .TX_DATA_VALID(TX_DATA_VALID), .SENT_CNT(SENT_CNT)
   );

   always #5 R_CLK = ~R_CLK;

   int tests = 0;
   int fails = 0;

   // model: transfer in flight, TX_BUSY seen, cycles since the last launch strobe
   bit         m_fly, m_seen;
   int         m_age;
   logic [7:0] m_byte;
   logic [15:0] m_cnt;

   // environment
   logic [7:0] fifo[$];
   int  start_dly = -1, busy_left = 0, busy_len = 10, dly_choice = 0;
   bit  respond = 1'b1, foreign = 1'b0, en_req = 1'b1, rst_req = 1'b0;
   int  cyc = 0, ren_cnt = 0, vld_cnt = 0, ren_cyc = 0;
   logic [7:0] cap[$];
   int  vcyc[$];
   bit  ren_s, vld_s;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endfunction

   function automatic bit exp_ren();
      return R_RST_n && !m_fly && TX_EN && !R_EMPTY && !TX_BUSY;
   endfunction

   function automatic void model_reset();
      m_fly = 0; m_seen = 0; m_age = 0; m_byte = 8'h00; m_cnt = 16'h0000;
   endfunction

   function automatic void model_step();
      if (!R_RST_n) begin
         model_reset();
      end else if (!m_fly) begin
         if (exp_ren()) begin
            m_fly = 1; m_seen = 0; m_age = 0; m_byte = R_DATA;
         end
      end else if (!m_seen) begin
         if (m_age == 0) m_age = 1;
         else if (TX_BUSY) m_seen = 1;
         else if (m_age == ST + 1) m_age = 0;
         else m_age++;
      end else if (!TX_BUSY) begin
         m_fly = 0;
         m_cnt++;
      end
   endfunction

   task automatic cycle();
      @(negedge R_CLK);
      cyc++;
      R_RST_n = rst_req;
      TX_EN   = en_req;
      if (start_dly == 0) begin busy_left = busy_len; start_dly = -1; end
      else if (start_dly > 0) start_dly--;
      TX_BUSY = (busy_left > 0) || foreign;
      if (busy_left > 0) busy_left--;
      R_EMPTY = (fifo.size() == 0);
      R_DATA  = R_EMPTY ? 8'($urandom) : fifo[0];
      #1;
      chk("r_en", {31'd0, R_EN}, {31'd0, exp_ren()});
      chk("tx_valid", {31'd0, TX_DATA_VALID}, {31'd0, (m_fly && !m_seen && m_age == 0)});
      chk("tx_data", {24'd0, TX_P_DATA}, {24'd0, m_byte});
      chk("sent_cnt", {16'd0, SENT_CNT}, {16'd0, m_cnt});
      ren_s = R_EN; vld_s = TX_DATA_VALID;
      if (ren_s) begin ren_cnt++; ren_cyc = cyc; end
      if (vld_s) begin vld_cnt++; cap.push_back(TX_P_DATA); vcyc.push_back(cyc); end
      @(posedge R_CLK);
      model_step();
      if (!R_RST_n) begin busy_left = 0; start_dly = -1; end
      if (ren_s && !R_EMPTY) void'(fifo.pop_front());
      if (vld_s && respond && start_dly < 0 && busy_left == 0) start_dly = dly_choice;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic clr();
      ren_cnt = 0; vld_cnt = 0; cap.delete(); vcyc.delete();
   endtask

   initial begin
      model_reset();
      // reset state with a fetch-worthy input pattern applied
      #2;
      R_EMPTY = 1'b0; R_DATA = 8'hA5; TX_EN = 1'b1; TX_BUSY = 1'b0;
      #1;
      chk("rst_r_en", {31'd0, R_EN}, 32'd0);
      chk("rst_valid", {31'd0, TX_DATA_VALID}, 32'd0);
      chk("rst_data", {24'd0, TX_P_DATA}, 32'd0);
      chk("rst_cnt", {16'd0, SENT_CNT}, 32'd0);
      run(2);
      rst_req = 1'b1;
      run(2);

      // single byte A5, TX busy for 10 cycles
      clr(); respond = 1; dly_choice = 0; busy_len = 10;
      fifo.push_back(8'hA5);
      run(20);
      chk("single_ren_pulses", ren_cnt, 1);
      chk("single_valid_pulses", vld_cnt, 1);
      if (cap.size() > 0) chk("single_data", {24'd0, cap[0]}, 32'hA5);
      if (vcyc.size() > 0) chk("single_latency", vcyc[0] - ren_cyc, 1);
      chk("single_cnt", {16'd0, SENT_CNT}, 32'd1);

      // empty FIFO
      clr();
      run(20);
      chk("empty_ren", ren_cnt, 0);
      chk("empty_valid", vld_cnt, 0);
      chk("empty_cnt", {16'd0, SENT_CNT}, 32'd1);

      // start timeout: TX never responds, then responds
      clr(); respond = 0;
      fifo.push_back(8'h3C);
      run(2 + 3 * PER);
      chk("to_ren", ren_cnt, 1);
      chk("to_pulses_ge3", {31'd0, vcyc.size() >= 3}, 32'd1);
      if (vcyc.size() >= 3) begin
         chk("to_gap1", vcyc[1] - vcyc[0], PER);
         chk("to_gap2", vcyc[2] - vcyc[1], PER);
      end
      respond = 1;
      run(2 * PER + 12);
      chk("to_cnt", {16'd0, SENT_CNT}, 32'd2);
      foreach (cap[i]) chk("to_data", {24'd0, cap[i]}, 32'h3C);

      // burst 01,02,03
      clr();
      fifo.push_back(8'h01); fifo.push_back(8'h02); fifo.push_back(8'h03);
      run(50);
      chk("burst_ren", ren_cnt, 3);
      chk("burst_n", cap.size(), 3);
      if (cap.size() == 3) begin
         chk("burst_d0", {24'd0, cap[0]}, 32'h01);
         chk("burst_d1", {24'd0, cap[1]}, 32'h02);
         chk("burst_d2", {24'd0, cap[2]}, 32'h03);
      end
      chk("burst_cnt", {16'd0, SENT_CNT}, 32'd5);

      // reset while in WAIT_DONE
      fifo.push_back(8'h77);
      for (int n = 0; n < 30 && !(m_fly && m_seen); n++) cycle();
      chk("reach_wait_done", {31'd0, (m_fly && m_seen)}, 32'd1);
      #3;
      R_RST_n = 1'b0; rst_req = 1'b0;
      #1;
      chk("mrst_r_en", {31'd0, R_EN}, 32'd0);
      chk("mrst_valid", {31'd0, TX_DATA_VALID}, 32'd0);
      chk("mrst_data", {24'd0, TX_P_DATA}, 32'd0);
      chk("mrst_cnt", {16'd0, SENT_CNT}, 32'd0);
      model_reset(); busy_left = 0; start_dly = -1;
      run(2);
      rst_req = 1'b1;
      clr();
      fifo.push_back(8'h88);
      run(20);
      chk("mrst_ren", ren_cnt, 1);
      if (cap.size() > 0) chk("mrst_next", {24'd0, cap[0]}, 32'h88);
      chk("mrst_cnt_after", {16'd0, SENT_CNT}, 32'd1);

      // counter wrap
      #2;
      force dut.SENT_CNT = 16'hFFFF;
      #1;
      release dut.SENT_CNT;
      m_cnt = 16'hFFFF;
      fifo.push_back(8'h5A);
      run(20);
      chk("wrap_cnt", {16'd0, SENT_CNT}, 32'd0);

      // TX_EN dropped in WAIT_START
      clr(); dly_choice = 3; busy_len = 4;
      fifo.push_back(8'hB1); fifo.push_back(8'hB2);
      for (int n = 0; n < 20 && !(m_fly && !m_seen && m_age > 0); n++) cycle();
      chk("reach_wait_start", {31'd0, (m_fly && !m_seen && m_age > 0)}, 32'd1);
      en_req = 1'b0;
      run(30);
      chk("gate_ren", ren_cnt, 1);
      chk("gate_cnt", {16'd0, SENT_CNT}, 32'd1);
      chk("gate_left", fifo.size(), 1);

      // random traffic
      en_req = 1'b1; respond = 1;
      for (int i = 0; i < 1500; i++) begin
         en_req = ($urandom_range(0, 9) != 0);
         foreign = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 5) == 0 && fifo.size() < 8) fifo.push_back(8'($urandom));
         dly_choice = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
         busy_len = $urandom_range(1, 12);
         cycle();
      end
      foreign = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
